// File: rtl/sample_pwm_sink.sv
// Audio output stage: buffers 8-bit offset-binary samples in a small FIFO, applies
// volume/mute and drives a registered single-bit PWM pin at a fixed sample rate.
module sample_pwm_sink #(
  parameter int unsigned DEPTH             = 4,
  parameter int unsigned FRAMES_PER_SAMPLE = 4,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned LW = $clog2(DEPTH) + 1,
  localparam int unsigned FW = (FRAMES_PER_SAMPLE > 1) ? $clog2(FRAMES_PER_SAMPLE) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    sample_in,
  input  logic          sample_valid,
  output logic          sample_ready,
  input  logic          play,
  input  logic          flush,
  input  logic [3:0]    volume,
  input  logic          mute,
  output logic          pwm_out,
  output logic          underrun,
  output logic [LW-1:0] fifo_level
);

  logic [7:0]    pcnt_q, pcnt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [7:0]    duty_q, duty_d;
  logic          pwm_q, pwm_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [7:0]    mem_q [DEPTH];

  logic frame_end;
  logic boundary;
  logic fifo_empty;
  logic push;
  logic pop;

  // Handshake: a sample transfers on a rising edge where sample_valid && sample_ready;
  // ready depends only on the registered level, never on sample_valid.
  assign sample_ready = (level_q != LW'(DEPTH));
  assign fifo_empty   = (level_q == '0);
  assign frame_end    = (pcnt_q == 8'hFF);
  assign boundary     = frame_end && (fcnt_q == FW'(FRAMES_PER_SAMPLE - 1));
  assign push         = sample_valid && sample_ready && !flush;
  assign pop          = boundary && play && !fifo_empty && !flush;
  assign underrun     = boundary && play && fifo_empty && !flush;

  assign pwm_out    = pwm_q;
  assign fifo_level = level_q;

  // Volume scaling of the head sample: duty = ((head - 128) * min(volume, 8)) >>> 3 + 128.
  logic [7:0]         head;
  logic [3:0]         vol_sat;
  logic signed [8:0]  s_val;
  logic signed [12:0] s_ext;
  logic signed [12:0] v_ext;
  logic signed [12:0] prod;
  logic [7:0]         scaled;
  logic               unused_prod_bits;

  assign head     = mem_q[rd_ptr_q];
  assign vol_sat  = (volume > 4'd8) ? 4'd8 : volume;
  assign s_val    = $signed({1'b0, head}) - 9'sd128;
  assign s_ext    = {{4{s_val[8]}}, s_val};
  assign v_ext    = {9'd0, vol_sat};
  assign prod     = s_ext * v_ext;
  // |prod| <= 1024, so the floor-shifted value always fits in prod[10:3].
  assign scaled   = prod[10:3] + 8'h80;
  assign unused_prod_bits = ^{prod[12:11], prod[2:0]};

  always_comb begin
    pcnt_d   = pcnt_q + 8'd1;
    fcnt_d   = fcnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    duty_d   = duty_q;

    if (frame_end) begin
      fcnt_d = boundary ? '0 : fcnt_q + FW'(1);
    end

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      duty_d   = 8'h80;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
      if (boundary) begin
        duty_d = pop ? scaled : 8'h80;
      end
    end

    pwm_d = (pcnt_q < (mute ? 8'h80 : duty_q));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcnt_q   <= '0;
      fcnt_q   <= '0;
      duty_q   <= 8'h80;
      pwm_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      pcnt_q   <= pcnt_d;
      fcnt_q   <= fcnt_d;
      duty_q   <= duty_d;
      pwm_q    <= pwm_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: the level counter decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push && reset) begin
      mem_q[wr_ptr_q] <= sample_in;
    end
  end

endmodule

// File: tb/tb_sample_pwm_sink.sv
// Directed bench for sample_pwm_sink: main instance with one frame per sample,
// a second instance with four frames per sample for sample-rate timing.
module tb_sample_pwm_sink;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] sample_in = 8'h00;
  logic       sample_valid = 1'b0;
  logic       play = 1'b0;
  logic       flush = 1'b0;
  logic [3:0] volume = 4'd8;
  logic       mute = 1'b0;

  logic       sample_ready, pwm_out, underrun;
  logic [2:0] fifo_level;
  logic       sample_ready4, pwm_out4, underrun4;
  logic [2:0] fifo_level4;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  sample_pwm_sink #(.DEPTH(4), .FRAMES_PER_SAMPLE(1)) u_dut (
    .clk(clk), .reset(rst_n), .sample_in(sample_in), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .play(play), .flush(flush), .volume(volume),
    .mute(mute), .pwm_out(pwm_out), .underrun(underrun), .fifo_level(fifo_level)
  );

  sample_pwm_sink #(.DEPTH(4), .FRAMES_PER_SAMPLE(4)) u_dut4 (
    .clk(clk), .reset(rst_n), .sample_in(sample_in), .sample_valid(sample_valid),
    .sample_ready(sample_ready4), .play(play), .flush(flush), .volume(volume),
    .mute(mute), .pwm_out(pwm_out4), .underrun(underrun4), .fifo_level(fifo_level4)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  // Driver tasks: inputs change and outputs are sampled on the falling edge.
  task automatic tick;
    @(negedge clk);
    cyc++;
  endtask

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    sample_in    = d;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  // Counts high cycles of the next full PWM frame (pcnt 0..255) on both instances.
  task automatic measure_frame(output int hi, output int hi4);
    while (cyc % 256 != 0) tick();
    hi  = 0;
    hi4 = 0;
    repeat (256) begin
      tick();
      hi  += int'(pwm_out);
      hi4 += int'(pwm_out4);
    end
  endtask

  logic [7:0] fill_data [5];
  int hi, hi4, un_cnt, un_bad, un4_cnt, un4_bad;

  initial begin
    fill_data[0] = 8'hC0;
    fill_data[1] = 8'h40;
    fill_data[2] = 8'hFF;
    fill_data[3] = 8'h20;
    fill_data[4] = 8'h00;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_pwm", int'(pwm_out), 0);
    check("rst_underrun", int'(underrun), 0);
    check("rst_level", int'(fifo_level), 0);
    check("rst_ready", int'(sample_ready), 1);
    rst_n = 1'b1;
    cyc   = 0;

    // Idle with play=0: 50% duty on both instances
    for (int f = 0; f < 4; f++) begin
      measure_frame(hi, hi4);
      check("idle_duty", hi, 128);
      check("idle_duty_fps4", hi4, 128);
    end
    check("idle_level", int'(fifo_level), 0);
    check("idle_ready", int'(sample_ready), 1);

    // Empty FIFO with play=1: one underrun per boundary, at the right cycle
    play = 1'b1;
    un_cnt = 0; un_bad = 0; un4_cnt = 0; un4_bad = 0;
    repeat (1024) begin
      tick();
      if (underrun) begin
        un_cnt++;
        if (cyc % 256 != 255) un_bad++;
      end
      if (underrun4) begin
        un4_cnt++;
        if (cyc % 1024 != 1023) un4_bad++;
      end
    end
    check("underrun_count", un_cnt, 4);
    check("underrun_pos", un_bad, 0);
    check("underrun_count_fps4", un4_cnt, 1);
    check("underrun_pos_fps4", un4_bad, 0);
    measure_frame(hi, hi4);
    check("underrun_duty", hi, 128);

    // Full-scale samples at volume 8
    volume = 4'd8;
    while (cyc % 256 != 10) tick();
    push(8'hFF);
    check("push1_level", int'(fifo_level), 1);
    push(8'h00);
    check("push2_level", int'(fifo_level), 2);
    measure_frame(hi, hi4);
    check("duty_ff_v8", hi, 255);
    measure_frame(hi, hi4);
    check("duty_00_v8", hi, 0);
    check("drain_level", int'(fifo_level), 0);

    // Volume scaling and saturation
    volume = 4'd4;
    push(8'hC0);
    measure_frame(hi, hi4);
    check("duty_c0_v4", hi, 160);
    push(8'h00);
    measure_frame(hi, hi4);
    check("duty_00_v4", hi, 64);
    volume = 4'd15;
    push(8'hC0);
    measure_frame(hi, hi4);
    check("duty_c0_v15", hi, 192);

    // Fill while paused: back-pressure after four pushes, fifth held off
    play   = 1'b0;
    volume = 4'd8;
    tick();
    for (int i = 0; i < 5; i++) begin
      sample_in    = fill_data[i];
      sample_valid = 1'b1;
      tick();
      if (i < 3) check("fill_ready", int'(sample_ready), 1);
      else       check("fill_ready_full", int'(sample_ready), 0);
    end
    sample_valid = 1'b0;
    check("fill_level", int'(fifo_level), 4);
    un_cnt = 0;
    repeat (300) begin
      tick();
      if (underrun) un_cnt++;
    end
    check("paused_no_underrun", un_cnt, 0);
    check("paused_level", int'(fifo_level), 4);
    play = 1'b1;
    while (cyc % 256 != 255) tick();
    check("ready_before_pop", int'(sample_ready), 0);
    tick();
    check("ready_after_pop", int'(sample_ready), 1);
    check("level_after_pop", int'(fifo_level), 3);
    measure_frame(hi, hi4);
    check("drain_c0", hi, 192);
    measure_frame(hi, hi4);
    check("drain_40", hi, 64);
    measure_frame(hi, hi4);
    check("drain_ff", hi, 255);
    measure_frame(hi, hi4);
    check("drain_20", hi, 32);
    measure_frame(hi, hi4);
    check("drain_held_off", hi, 128);
    check("drain_level_end", int'(fifo_level), 0);

    // Mute mid-frame reaches the pin one cycle later
    push(8'hFF);
    push(8'h00);
    while (cyc % 256 != 0) tick();
    while (cyc % 256 != 200) tick();
    check("pre_mute_pwm", int'(pwm_out), 1);
    mute = 1'b1;
    tick();
    check("mute_lag_pwm", int'(pwm_out), 0);
    measure_frame(hi, hi4);
    check("muted_duty", hi, 128);
    mute = 1'b0;
    push(8'h00);
    measure_frame(hi, hi4);
    check("unmuted_duty", hi, 0);

    // Flush with a simultaneous push
    play = 1'b0;
    push(8'h11);
    push(8'h22);
    push(8'h33);
    check("pre_flush_level", int'(fifo_level), 3);
    flush        = 1'b1;
    sample_in    = 8'hFF;
    sample_valid = 1'b1;
    tick();
    flush        = 1'b0;
    sample_valid = 1'b0;
    check("flush_level", int'(fifo_level), 0);
    check("flush_ready", int'(sample_ready), 1);
    play = 1'b1;
    while (cyc % 256 != 255) tick();
    check("flush_underrun", int'(underrun), 1);
    measure_frame(hi, hi4);
    check("flush_duty", hi, 128);

    // Reset asserted mid-frame clears state at once
    push(8'hFF);
    check("pre_reset_level", int'(fifo_level), 1);
    while (cyc % 256 != 50) tick();
    rst_n = 1'b0;
    tick();
    check("midreset_level", int'(fifo_level), 0);
    check("midreset_ready", int'(sample_ready), 1);
    check("midreset_pwm", int'(pwm_out), 0);
    check("midreset_underrun", int'(underrun), 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
